// File: rtl/ram_arbiter_pkg.sv
// Types and helpers shared by the RAM arbiter and its winner-select sub-module.
`include "rv_defs.v"

package ram_arbiter_pkg;

  typedef enum logic {
    OwnM0 = `ARB_M0,
    OwnM1 = `ARB_M1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_req_t;

  // A halfword store starting at byte 3 would straddle the word boundary.
  function automatic logic is_misaligned(input ram_req_t req);
    return req.we && (req.mem_ctrl == `STORE_HW) && (req.addr[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select for the RAM arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin contention instead of starvation-limited priority.
module arb_pick
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic [1:0]       i_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e           i_last_gnt,
`else
  input  logic [CNT_W-1:0] i_starve_cnt,
`endif
  output logic [1:0]       o_gnt,
  output owner_e           o_winner
);

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);
`endif

  logic w_m1_pref;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_m1_pref = (i_last_gnt == OwnM0);
`else
    w_m1_pref = (i_starve_cnt >= Limit);
`endif
    o_gnt    = 2'b00;
    o_winner = OwnM0;
    case (i_req)
      2'b01: begin
        o_gnt    = 2'b01;
        o_winner = OwnM0;
      end
      2'b10: begin
        o_gnt    = 2'b10;
        o_winner = OwnM1;
      end
      2'b11: begin
        o_gnt    = w_m1_pref ? 2'b10 : 2'b01;
        o_winner = w_m1_pref ? OwnM1 : OwnM0;
      end
      default: begin
        o_gnt    = 2'b00;
        o_winner = OwnM0;
      end
    endcase
  end

endmodule

// File: rtl/rv_defs.v
// Shared core defines: store sizes and RAM arbiter owner encodings.
`ifndef RV_DEFS_V
`define RV_DEFS_V

`define STORE_B  2'b00
`define STORE_HW 2'b01
`define STORE_W  2'b10

`define ARB_M0 1'b0
`define ARB_M1 1'b1

`endif

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the core load/store path (m0) and the loader (m1).
// ARB_ROUND_ROBIN_EN swaps the starvation counter for round-robin contention.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_mem_ctrl,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_mem_ctrl,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_we,
  output logic [1:0]  ram_mem_ctrl,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  ram_req_t   w_m0, w_m1, w_win;
  logic [1:0] w_req, w_gnt;
  owner_e     w_winner;
  logic       w_any, w_mis, w_load;
  logic       r_rd_pend;
  owner_e     r_rd_owner;

  assign w_m0  = {m0_we, m0_mem_ctrl, m0_addr, m0_wdata};
  assign w_m1  = {m1_we, m1_mem_ctrl, m1_addr, m1_wdata};
  // Grants are held off for the whole reset cycle.
  assign w_req = {m1_req, m0_req} & {2{~rst}};

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= OwnM1;
    end else if (w_any) begin
      r_last_gnt <= w_winner;
    end
  end
`else
  logic [CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (m1_req && !w_gnt[1]) begin
      if (r_starve_cnt != '1) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`endif

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .i_req        (w_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_gnt   (r_last_gnt),
`else
    .i_starve_cnt (r_starve_cnt),
`endif
    .o_gnt        (w_gnt),
    .o_winner     (w_winner)
  );

  assign w_any  = |w_gnt;
  assign w_win  = (w_winner == OwnM1) ? w_m1 : w_m0;
  assign w_mis  = w_any && is_misaligned(w_win);
  assign w_load = w_any && !w_win.we;

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];
  assign m0_err = w_gnt[0] && w_mis;
  assign m1_err = w_gnt[1] && w_mis;

  // Idle cycles drive an all-zero request; the resulting read of address 0 is never reported.
  always_comb begin
    ram_we       = 1'b0;
    ram_mem_ctrl = 2'b00;
    ram_addr     = '0;
    ram_wdata    = '0;
    if (w_any) begin
      ram_we       = w_win.we && !w_mis;
      ram_mem_ctrl = w_win.mem_ctrl;
      ram_addr     = w_win.addr;
      ram_wdata    = w_win.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OwnM0;
    end else begin
      r_rd_pend <= w_load;
      if (w_load) begin
        r_rd_owner <= w_winner;
      end
    end
  end

  assign m0_rvalid = r_rd_pend && !rst && (r_rd_owner == OwnM0);
  assign m1_rvalid = r_rd_pend && !rst && (r_rd_owner == OwnM1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM (registered read, byte/halfword/word store via mem_ctrl) between two requesters.
  - m0: core load/store path.
  - m1: debug/program loader.
- One access is issued per cycle with a combinational grant. Read data returns one cycle after issue, tagged to the requester that issued the read.
- Arbitration is fixed priority to m0, with a starvation counter that guarantees m1 progress.
- Sits between the load/store stage, the loader, and the ram instance.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles m1 may be refused before it is forced to win; legal range 1..15.
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  access request, held with payload until m0_gnt
- m0_we  in  1  1=store, 0=load
- m0_mem_ctrl  in  2  store size, `STORE_B/`STORE_HW/`STORE_W
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  load data valid
- m0_rdata  out  32  load data
- m0_err  out  1  one-cycle pulse, misaligned store rejected
- m1_*  same set as m0_*
- ram_we  out  1  to ram.we
- ram_mem_ctrl  out  2  to ram.mem_ctrl
- ram_addr  out  32  to ram.address
- ram_wdata  out  32  to ram.data_in
- ram_rdata  in  32  from ram.data_out

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - All gnt, rvalid and err outputs are 0; all rdata outputs are 0.
  - ram_we is 0.
  - Internal registers clear: rd_pend_q=0, rd_owner_q=0, starve_cnt=0.
- Grant (combinational, same cycle):
  - Only m0_req: m0 wins.
  - Only m1_req: m1 wins.
  - Both requesting: m0 wins unless starve_cnt >= STARVE_LIMIT, in which case m1 wins.
  - At most one gnt is high per cycle.
- RAM drive:
  - The winner's we/mem_ctrl/addr/wdata drive the ram_* ports, with addr passed unmodified.
  - No winner: ram_we=0, ram_addr=0, ram_mem_ctrl=0, ram_wdata=0. The RAM then performs a don't-care read of address 0, which is never reported.
- Stores complete in the grant cycle. There is no rvalid for stores.
- Loads:
  - On a granted load (we=0): rd_pend_q<=1 and rd_owner_q<=winner.
  - Next cycle: rvalid of the owner is 1 and its rdata=ram_rdata. The other requester's rdata is held at 0.
  - A cycle with no granted load sets rd_pend_q<=0.
  - Back-to-back loads are allowed, including alternating owners. Each rvalid follows its own grant by exactly 1 cycle.
  - A store granted in the cycle after a load does not disturb the pending rdata, because the RAM holds data_out while we=1.
- Misaligned store: `STORE_HW with addr[1:0]==2'b11.
  - Request is granted (consumed).
  - ram_we is forced to 0, so RAM contents are unchanged.
  - The requester's err pulses in the grant cycle.
  - `STORE_W ignores addr[1:0].
- Starvation counter:
  - Increments, saturating at 2**CNT_W-1, each cycle m1_req=1 and m1_gnt=0.
  - Clears on m1_gnt or when m1_req=0.
- Reset mid-operation:
  - A pending rvalid is dropped; no rvalid appears the cycle after rst.
  - Grants are suppressed while rst=1.
- Protocol: requesters must not change the payload while req=1 and gnt=0. The arbiter does not check this.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On contention, the winner is the requester not granted most recently; a last_gnt_q register resets to m1, so m0 wins the first contention.
  - starve_cnt and STARVE_LIMIT are unused, and starve_cnt is not instantiated.
- Undefined: fixed priority with the starvation counter, as described above.

Decomposition:
- `STORE_B/`STORE_HW/`STORE_W come from rv_defs.v and are included, not redefined.
- Add to rv_defs.v: `ARB_M0=1'b0, `ARB_M1=1'b1 owner encodings.
- One natural sub-module: arb_pick.
  - Combinational winner select from the two reqs, starve_cnt/last_gnt and the limit.
  - Outputs a grant vector and a winner index.

Test Plan:
- Single m0 store then load: m0 stores `STORE_W 0xDEADBEEF at addr 0x8, then loads addr 0x8 -> m0_gnt in both cycles; m0_rvalid=1 with m0_rdata=0xDEADBEEF exactly one cycle after the load grant; m1_rvalid stays 0.
- Contention: m0_req and m1_req held high continuously, STARVE_LIMIT=4 -> m0 granted cycles 0-3, m1 granted cycle 4, counter cleared; pattern repeats with period 5.
- Alternating loads: m0 loads addr 0x4 (value 0x11), then m1 loads addr 0x8 (value 0x22) on consecutive cycles -> m0_rvalid/0x11, then m1_rvalid/0x22 on the next consecutive cycles.
- Misaligned store: m1 sends `STORE_HW at addr 0x7 with wdata 0xABCD -> m1_gnt=1, m1_err=1 for one cycle, ram_we=0; a later word read of that location is unchanged.
- Reset mid-read: m0 load granted, rst=1 in the next cycle -> m0_rvalid=0 and all outputs at reset values; after rst deassert, idle cycles show ram_we=0 and no rvalid.
- With ARB_ROUND_ROBIN_EN: both reqs continuous -> grants strictly alternate m0, m1, m0, m1 starting with m0.
